// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width defaults, funct3 codes,
// FSM state encoding and the funct3 legality/size decoder.
package load_store_unit_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;
    localparam logic [2:0] F3_WORD_U = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_ACC1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] size_log2;
        logic       is_unsigned;
    } f3_decode_t;

    // wide_en: the 64-bit only encodings (D, WU) are legal
    function automatic f3_decode_t decode_f3(input logic [2:0] func3, input logic we,
                                             input logic wide_en);
        f3_decode_t d;
        d.legal       = 1'b1;
        d.size_log2   = 2'd0;
        d.is_unsigned = 1'b0;
        case (func3)
            F3_BYTE:   d.size_log2 = 2'd0;
            F3_HALF:   d.size_log2 = 2'd1;
            F3_WORD:   d.size_log2 = 2'd2;
            F3_DOUBLE: begin
                d.size_log2 = 2'd3;
                d.legal     = wide_en;
            end
            F3_BYTE_U: begin
                d.is_unsigned = 1'b1;
                d.legal       = !we;
            end
            F3_HALF_U: begin
                d.size_log2   = 2'd1;
                d.is_unsigned = 1'b1;
                d.legal       = !we;
            end
            F3_WORD_U: begin
                d.size_log2   = 2'd2;
                d.is_unsigned = 1'b1;
                d.legal       = !we && wide_en;
            end
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane/alignment datapath: byte lanes and shifted store data over
// two words, plus load extraction and sign/zero extension from two read words.
module lsu_align #(
    parameter  int DATA_WIDTH = 32,
    localparam int STRB       = DATA_WIDTH / 8,
    localparam int OFS        = $clog2(STRB)
) (
    input  logic [1:0]              size_log2,
    input  logic [OFS-1:0]          ofs,
    input  logic                    is_unsigned,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata0,
    input  logic [DATA_WIDTH-1:0]   rdata1,
    output logic [2*STRB-1:0]       lanes,
    output logic [2*DATA_WIDTH-1:0] wide_wdata,
    output logic [DATA_WIDTH-1:0]   load_data
);

    logic [2*STRB-1:0]       size_mask;
    logic [2*DATA_WIDTH-1:0] wdata_ext;
    logic [2*DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0]   rdata_low;
    logic                    sign_bit;

    always_comb begin
        size_mask = '0;
        wdata_ext = '0;
        for (int i = 0; i < STRB; i++) begin
            if (i < (1 << size_log2)) begin
                size_mask[i]        = 1'b1;
                wdata_ext[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        lanes      = size_mask << ofs;
        wide_wdata = wdata_ext << {ofs, 3'b000};

        rdata_shift = {rdata1, rdata0} >> {ofs, 3'b000};
        rdata_low   = rdata_shift[DATA_WIDTH-1:0];

        // sign comes from the top byte of the access, not of the word
        sign_bit = 1'b0;
        for (int i = 0; i < STRB; i++) begin
            if (i == (1 << size_log2) - 1) sign_bit = rdata_low[i*8+7];
        end
        sign_bit = sign_bit && !is_unsigned;

        load_data = '0;
        for (int i = 0; i < STRB; i++) begin
            load_data[i*8 +: 8] = (i < (1 << size_log2)) ? rdata_low[i*8 +: 8] : {8{sign_bit}};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit between execute and the data BRAM port.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats.
//
// state  | meaning
// IDLE   | ready for a request
// ACC0   | first (or only) memory beat requested, waiting for gnt
// WAIT0  | load beat 0 granted, waiting for rvalid
// ACC1   | second beat of a crossing access requested
// WAIT1  | load beat 1 granted, waiting for rvalid
// RESP   | one-cycle completion pulse
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_func3,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      mem_req,
    input  logic                      mem_gnt,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_enb,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_rvalid,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);

    localparam int   STRB    = DATA_WIDTH / 8;
    localparam int   OFS     = $clog2(STRB);
    localparam logic WIDE_EN = (DATA_WIDTH == 64);

    lsu_state_e state, state_next;

    logic                    we_q, uns_q, err_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rdata0_q, rdata1_q;
    f3_decode_t              dec;
    logic                    accept, req_ok, crossing;
    logic [2*STRB-1:0]       lanes;
    logic [2*DATA_WIDTH-1:0] wide_wdata;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [ADDR_WIDTH-1:0]   beat0_addr;

    assign dec        = decode_f3(req_func3, req_we, WIDE_EN);
    assign accept     = req_valid && (state == ST_IDLE);
    assign beat0_addr = {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

`ifdef LSU_MISALIGNED_EN
    assign req_ok   = dec.legal;
    assign crossing = |lanes[2*STRB-1:STRB];
`else
    // without beat splitting only naturally aligned accesses are legal
    assign req_ok   = dec.legal &&
                      !(|(req_addr[OFS-1:0] & OFS'((1 << dec.size_log2) - 1)));
    assign crossing = 1'b0;
    assign rdata1_q = '0;
    logic unused_beat1;
    assign unused_beat1 = ^{lanes[2*STRB-1:STRB], wide_wdata[2*DATA_WIDTH-1:DATA_WIDTH]};
`endif

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_log2   (size_q),
        .ofs         (addr_q[OFS-1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata0      (rdata0_q),
        .rdata1      (rdata1_q),
        .lanes       (lanes),
        .wide_wdata  (wide_wdata),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
`ifdef LSU_MISALIGNED_EN
            rdata1_q <= '0;
`endif
        end else begin
            if (accept) begin
                we_q     <= req_we;
                uns_q    <= dec.is_unsigned;
                err_q    <= !req_ok;
                size_q   <= dec.size_log2;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata0_q <= '0;
`ifdef LSU_MISALIGNED_EN
                rdata1_q <= '0;
`endif
            end
            if (state == ST_WAIT0 && mem_rvalid) rdata0_q <= mem_rdata;
`ifdef LSU_MISALIGNED_EN
            if (state == ST_WAIT1 && mem_rvalid) rdata1_q <= mem_rdata;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = req_ok ? ST_ACC0 : ST_RESP;
            ST_ACC0:  if (mem_gnt) begin
                if (!we_q)        state_next = ST_WAIT0;
                else if (crossing) state_next = ST_ACC1;
                else              state_next = ST_RESP;
            end
            ST_WAIT0: if (mem_rvalid) state_next = crossing ? ST_ACC1 : ST_RESP;
`ifdef LSU_MISALIGNED_EN
            ST_ACC1:  if (mem_gnt) state_next = we_q ? ST_RESP : ST_WAIT1;
            ST_WAIT1: if (mem_rvalid) state_next = ST_RESP;
`endif
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == ST_IDLE);
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_byte_enb = '0;
        mem_wdata    = '0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        case (state)
            ST_ACC0: begin
                mem_req      = 1'b1;
                mem_we       = we_q;
                mem_addr     = beat0_addr;
                mem_byte_enb = lanes[STRB-1:0];
                mem_wdata    = we_q ? wide_wdata[DATA_WIDTH-1:0] : '0;
            end
`ifdef LSU_MISALIGNED_EN
            ST_ACC1: begin
                mem_req      = 1'b1;
                mem_we       = we_q;
                mem_addr     = beat0_addr + ADDR_WIDTH'(STRB);
                mem_byte_enb = lanes[2*STRB-1:STRB];
                mem_wdata    = we_q ? wide_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            end
`endif
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : load_data;
            end
            default: ;
        endcase
    end

endmodule
